// File: rtl/tft_pkg.sv
// -----------------------------------------------------------------------------
// tft_pkg -- shared definitions for the TFT rectangle-fill engine.
//
// Holds the panel geometry, the MIPI-DCS window/memory-write opcodes, the
// D/C line encodings, the fill FSM state type and the counter widths used by
// tft_rect_fill and tft_byte_tx.
//
// Optional feature: TFT_FILL_RGB565_EN (see tft_rect_fill) selects 2-byte
// RGB565 pixels instead of the default 3-byte RGB666 stream.
// -----------------------------------------------------------------------------
package tft_pkg;

  localparam int unsigned PANEL_W = 320;
  localparam int unsigned PANEL_H = 480;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  // Cycles to wait for the transmitter to raise busy before assuming the
  // byte went out anyway.
  localparam int unsigned ACK_TIMEOUT = 4;

  // CASET + 4 data, RASET + 4 data, RAMWR.
  localparam int unsigned HDR_BYTES = 11;

  // 320 * 480 = 153600 pixels fits in 18 bits.
  localparam int unsigned PIX_CNT_W = 18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_FINISH
  } fill_state_e;

  // Upper byte of a 9-bit coordinate, zero-extended.
  function automatic logic [7:0] coord_hi(input logic [8:0] v);
    return {7'b0, v[8]};
  endfunction

endpackage

// File: rtl/tft_byte_tx.sv
// -----------------------------------------------------------------------------
// tft_byte_tx -- single-byte handshake towards the TFT byte transmitter.
//
// When req is high and the transmitter is idle, registers dc/data onto the
// tft_* lines and pulses tft_transmit for one cycle. It then watches tft_busy
// for up to ACK_TIMEOUT cycles and pulses ack when busy is seen high or the
// window expires (a transmitter that never reports busy is treated as having
// taken the byte). The caller waits for tft_busy to fall before the next req.
//
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   req             send the byte on dc/data (honoured only while !tft_busy)
//   dc, data        byte and D/C flag to send
//   tft_busy        transmitter busy
//   ack             one-cycle: strobe acknowledged (busy seen or timeout)
//   tft_dc/data     held from one strobe to the next
//   tft_transmit    one-cycle send strobe
// -----------------------------------------------------------------------------
module tft_byte_tx
  import tft_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       dc,
  input  logic [7:0] data,
  input  logic       tft_busy,
  output logic       ack,
  output logic       tft_dc,
  output logic [7:0] tft_data,
  output logic       tft_transmit
);

  localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT);

  logic             tx_q,   tx_d;
  logic             dc_q,   dc_d;
  logic [7:0]       data_q, data_d;
  logic             wait_q, wait_d;
  logic [TMO_W-1:0] tmo_q,  tmo_d;
  logic             tmo_hit;

  // NOTE: every _d signal is given its default first, so no path through
  // this block leaves a value unassigned and no latch is inferred.
  always_comb begin
    tx_d   = 1'b0;
    dc_d   = dc_q;
    data_d = data_q;
    wait_d = wait_q;
    tmo_d  = tmo_q;

    tmo_hit = (tmo_q == TMO_W'(ACK_TIMEOUT - 1));
    ack     = wait_q && (tft_busy || tmo_hit);

    if (req && !tft_busy) begin
      tx_d   = 1'b1;
      dc_d   = dc;
      data_d = data;
    end

    // The ack window opens the cycle after the strobe is on the wire.
    if (tx_q) begin
      wait_d = 1'b1;
      tmo_d  = '0;
    end else if (wait_q) begin
      if (ack) wait_d = 1'b0;
      else     tmo_d  = tmo_q + 1'b1;
    end
  end

  // NOTE: reset is synchronous, so it is just the first branch inside the
  // clocked block; non-blocking assignments make every flop sample the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_q   <= 1'b0;
      dc_q   <= DC_CMD;
      data_q <= 8'h00;
      wait_q <= 1'b0;
      tmo_q  <= '0;
    end else begin
      tx_q   <= tx_d;
      dc_q   <= dc_d;
      data_q <= data_d;
      wait_q <= wait_d;
      tmo_q  <= tmo_d;
    end
  end

  assign tft_transmit = tx_q;
  assign tft_dc       = dc_q;
  assign tft_data     = data_q;

endmodule

// File: rtl/tft_rect_fill.sv
// -----------------------------------------------------------------------------
// tft_rect_fill -- fill a rectangle of a 320x480 TFT with one colour.
//
// On a valid start in IDLE, captures the bounds and colour, then emits
// CASET x0,x1 / RASET y0,y1 / RAMWR followed by (x1-x0+1)*(y1-y0+1) pixels
// through tft_byte_tx. Out-of-range or inverted bounds pulse err instead.
//
// Configuration macro: TFT_FILL_RGB565_EN -- when defined each pixel is two
// bytes {R[7:3],G[7:5]}, {G[4:2],B[7:3]}; otherwise three bytes R, G, B.
//
// Ports:
//   clk, rst             clock, synchronous active-low reset
//   start                request, sampled only in IDLE
//   x0, x1, y0, y1       inclusive column/row bounds
//   color                {R,G,B}
//   tft_busy             transmitter busy
//   tft_dc/data/transmit byte interface to the transmitter
//   busy                 fill in progress (every state but IDLE)
//   done                 one-cycle completion pulse
//   err                  one-cycle pulse on a rejected request
// -----------------------------------------------------------------------------
module tft_rect_fill
  import tft_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [8:0]  x0,
  input  logic [8:0]  x1,
  input  logic [8:0]  y0,
  input  logic [8:0]  y1,
  input  logic [23:0] color,
  input  logic        tft_busy,
  output logic        tft_dc,
  output logic [7:0]  tft_data,
  output logic        tft_transmit,
  output logic        busy,
  output logic        done,
  output logic        err
);

`ifdef TFT_FILL_RGB565_EN
  localparam logic [1:0] LAST_COMP = 2'd1;
`else
  localparam logic [1:0] LAST_COMP = 2'd2;
`endif

  fill_state_e          state_q,    state_d;
  logic [8:0]           x0_q,       x0_d;
  logic [8:0]           x1_q,       x1_d;
  logic [8:0]           y0_q,       y0_d;
  logic [8:0]           y1_q,       y1_d;
  logic [23:0]          color_q,    color_d;
  logic [PIX_CNT_W-1:0] pix_left_q, pix_left_d;
  logic [3:0]           hdr_idx_q,  hdr_idx_d;
  logic [1:0]           comp_q,     comp_d;
  logic                 err_q,      err_d;

  logic                 req_ok;
  logic [8:0]           w_span, h_span;
  logic [PIX_CNT_W-1:0] npix;
  logic                 in_pixels, last_byte;
  logic                 cur_dc;
  logic [7:0]           cur_data;
  logic                 tx_req, tx_ack;
  logic [7:0]           r_b, g_b, b_b;

  // Request validation and pixel count straight from the inputs, used only
  // on the start cycle.
  always_comb begin
    req_ok = (x1 >= x0) && (y1 >= y0) &&
             (x1 <= 9'(PANEL_W - 1)) && (y1 <= 9'(PANEL_H - 1));
    w_span = x1 - x0 + 9'd1;
    h_span = y1 - y0 + 9'd1;
    npix   = PIX_CNT_W'(w_span) * PIX_CNT_W'(h_span);
  end

  // Byte currently owed to the panel: 11 header bytes, then pixel components.
  always_comb begin
    {r_b, g_b, b_b} = color_q;
    in_pixels = (hdr_idx_q == 4'(HDR_BYTES));
    last_byte = in_pixels && (comp_q == LAST_COMP) && (pix_left_q == PIX_CNT_W'(1));
    cur_dc    = DC_DATA;
    cur_data  = 8'h00;
    case (hdr_idx_q)
      4'd0:    begin cur_dc = DC_CMD; cur_data = CMD_CASET; end
      4'd1:    cur_data = coord_hi(x0_q);
      4'd2:    cur_data = x0_q[7:0];
      4'd3:    cur_data = coord_hi(x1_q);
      4'd4:    cur_data = x1_q[7:0];
      4'd5:    begin cur_dc = DC_CMD; cur_data = CMD_RASET; end
      4'd6:    cur_data = coord_hi(y0_q);
      4'd7:    cur_data = y0_q[7:0];
      4'd8:    cur_data = coord_hi(y1_q);
      4'd9:    cur_data = y1_q[7:0];
      4'd10:   begin cur_dc = DC_CMD; cur_data = CMD_RAMWR; end
      default: begin
`ifdef TFT_FILL_RGB565_EN
        if (comp_q == 2'd0) cur_data = {r_b[7:3], g_b[7:5]};
        else                cur_data = {g_b[4:2], b_b[7:3]};
`else
        case (comp_q)
          2'd0:    cur_data = r_b;
          2'd1:    cur_data = g_b;
          default: cur_data = b_b;
        endcase
`endif
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    y0_d       = y0_q;
    y1_d       = y1_q;
    color_d    = color_q;
    pix_left_d = pix_left_q;
    hdr_idx_d  = hdr_idx_q;
    comp_d     = comp_q;
    err_d      = 1'b0;
    tx_req     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (req_ok) begin
            x0_d       = x0;
            x1_d       = x1;
            y0_d       = y0;
            y1_d       = y1;
            color_d    = color;
            pix_left_d = npix;
            hdr_idx_d  = '0;
            comp_d     = '0;
            state_d    = ST_SEND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SEND: begin
        // tft_byte_tx strobes on exactly this condition.
        tx_req = 1'b1;
        if (!tft_busy) state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (tx_ack) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!tft_busy) begin
          if (last_byte) begin
            state_d = ST_FINISH;
          end else begin
            state_d = ST_SEND;
            if (!in_pixels) begin
              hdr_idx_d = hdr_idx_q + 4'd1;
            end else if (comp_q == LAST_COMP) begin
              comp_d     = '0;
              pix_left_d = pix_left_q - PIX_CNT_W'(1);
            end else begin
              comp_d = comp_q + 2'd1;
            end
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      x0_q       <= '0;
      x1_q       <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      color_q    <= '0;
      pix_left_q <= '0;
      hdr_idx_q  <= '0;
      comp_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      y0_q       <= y0_d;
      y1_q       <= y1_d;
      color_q    <= color_d;
      pix_left_q <= pix_left_d;
      hdr_idx_q  <= hdr_idx_d;
      comp_q     <= comp_d;
      err_q      <= err_d;
    end
  end

  tft_byte_tx u_byte_tx (
    .clk          (clk),
    .rst          (rst),
    .req          (tx_req),
    .dc           (cur_dc),
    .data         (cur_data),
    .tft_busy     (tft_busy),
    .ack          (tx_ack),
    .tft_dc       (tft_dc),
    .tft_data     (tft_data),
    .tft_transmit (tft_transmit)
  );

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_FINISH);
  assign err  = err_q;

endmodule

// File: tb/tb_tft_rect_fill.sv
// -----------------------------------------------------------------------------
// tb_tft_rect_fill -- self-checking bench for tft_rect_fill.
//
// A transmitter model drives tft_busy (fixed, never-busy or random timing).
// Every strobe is compared against a byte queue built from the rectangle
// and colour with plain arithmetic. Literal byte lists pin the model on a
// few hand-worked cases. Honours TFT_FILL_RGB565_EN.
// -----------------------------------------------------------------------------
module tb_tft_rect_fill;

`ifdef TFT_FILL_RGB565_EN
  localparam int BPP = 2;
`else
  localparam int BPP = 3;
`endif
  localparam int BUDGET = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  x0 = '0, x1 = '0, y0 = '0, y1 = '0;
  logic [23:0] color = '0;
  logic        tft_busy = 1'b0;
  logic        tft_dc, tft_transmit, busy, done, err;
  logic [7:0]  tft_data;

  tft_rect_fill dut (
    .clk(clk), .rst(rst), .start(start),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color),
    .tft_busy(tft_busy), .tft_dc(tft_dc), .tft_data(tft_data),
    .tft_transmit(tft_transmit), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int strobes = 0, done_cnt = 0, err_cnt = 0, busy_cycles = 0;
  int busy_mode = 0;
  int pend = 0, hold = 0, hold_len = 8;
  int cyc = 0, last_strobe_cyc = -1;
  bit prev_tx = 1'b0, prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference byte stream for a fill, straight from the byte-order rules.
  task automatic build(input int a0, input int a1, input int b0, input int b1,
                       input logic [23:0] c, input int limit);
    logic [8:0] q[$];
    logic [7:0] r, g, b;
    int n;
    {r, g, b} = c;
    q.push_back({1'b0, 8'h2A});
    q.push_back({1'b1, 8'(a0 / 256)}); q.push_back({1'b1, 8'(a0 % 256)});
    q.push_back({1'b1, 8'(a1 / 256)}); q.push_back({1'b1, 8'(a1 % 256)});
    q.push_back({1'b0, 8'h2B});
    q.push_back({1'b1, 8'(b0 / 256)}); q.push_back({1'b1, 8'(b0 % 256)});
    q.push_back({1'b1, 8'(b1 / 256)}); q.push_back({1'b1, 8'(b1 % 256)});
    q.push_back({1'b0, 8'h2C});
    n = (a1 - a0 + 1) * (b1 - b0 + 1);
    for (int p = 0; p < n && q.size() < limit; p++) begin
`ifdef TFT_FILL_RGB565_EN
      q.push_back({1'b1, r[7:3], g[7:5]});
      q.push_back({1'b1, g[4:2], b[7:3]});
`else
      q.push_back({1'b1, r});
      q.push_back({1'b1, g});
      q.push_back({1'b1, b});
`endif
    end
    exp_q = q;
  endtask

  // Monitor, compare process and transmitter model, all off the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (tft_transmit) begin
        check("strobe_while_busy", {31'b0, tft_busy}, 0);
        if (prev_tx) check("strobe_one_cycle", 1, 0);
        if (busy_mode == 1 && last_strobe_cyc >= 0)
          check("timeout_gap", {31'b0, (cyc - last_strobe_cyc) > 4}, 1);
        last_strobe_cyc = cyc;
        got_q.push_back({tft_dc, tft_data});
        if (exp_q.size() == 0) check("unexpected_strobe", {23'b0, tft_dc, tft_data}, 32'h1FF);
        else                   check("byte", {23'b0, tft_dc, tft_data}, {23'b0, exp_q.pop_front()});
        strobes++;
      end
      if (done) begin
        done_cnt++;
        check("busy_during_done", {31'b0, busy}, 1);
      end
      if (prev_done) check("busy_after_done", {31'b0, busy}, 0);
      if (err)  err_cnt++;
      if (busy) busy_cycles++;
    end
    prev_tx   = tft_transmit && rst;
    prev_done = done && rst;

    if (!rst) begin
      pend = 0; hold = 0; tft_busy = 1'b0;
    end else begin
      if (hold > 0) begin
        hold--;
        if (hold == 0) tft_busy = 1'b0;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin tft_busy = 1'b1; hold = hold_len; end
      end
      if (tft_transmit) begin
        case (busy_mode)
          0: begin pend = 1; hold_len = 8; end
          2: begin pend = $urandom_range(1, 3); hold_len = $urandom_range(1, 6); end
          default: ;
        endcase
      end
    end
  end

  task automatic run_fill(input int a0, input int a1, input int b0, input int b1,
                          input logic [23:0] c, input int mode, input bit inject);
    int d0, e0, s0, n;
    busy_mode = mode;
    got_q.delete();
    build(a0, a1, b0, b1, c, 1 << 30);
    d0 = done_cnt; e0 = err_cnt; s0 = strobes;
    last_strobe_cyc = -1;
    @(posedge clk); #1;
    start = 1'b1; x0 = 9'(a0); x1 = 9'(a1); y0 = 9'(b0); y1 = 9'(b1); color = c;
    @(posedge clk); #1;
    start = 1'b0;
    x0 = 9'($urandom); x1 = 9'($urandom); y0 = 9'($urandom); y1 = 9'($urandom);
    color = 24'($urandom);
    n = 0;
    while (done_cnt == d0 && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
      // A second request mid-fill (often invalid) must be ignored.
      start = inject && (n == 25) && busy;
    end
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("fill_in_budget", {31'b0, n < BUDGET}, 1);
    check("done_pulses", done_cnt - d0, 1);
    check("no_err_during_fill", err_cnt - e0, 0);
    check("strobe_count", strobes - s0, 11 + (a1 - a0 + 1) * (b1 - b0 + 1) * BPP);
    check("model_bytes_left", exp_q.size(), 0);
  endtask

  task automatic bad_start(input int a0, input int a1, input int b0, input int b1);
    int e0, s0, bc0;
    e0 = err_cnt; s0 = strobes; bc0 = busy_cycles;
    exp_q.delete();
    @(posedge clk); #1;
    start = 1'b1; x0 = 9'(a0); x1 = 9'(a1); y0 = 9'(b0); y1 = 9'(b1);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("err_pulse", err_cnt - e0, 1);
    check("err_no_strobe", strobes - s0, 0);
    check("err_busy_low", busy_cycles - bc0, 0);
  endtask

  task automatic cmp_lit(input string nm, input logic [8:0] lit[$]);
    for (int i = 0; i < lit.size(); i++) begin
      if (i < got_q.size()) check(nm, {23'b0, got_q[i]}, {23'b0, lit[i]});
      else                  check(nm, 32'hDEAD, {23'b0, lit[i]});
    end
  endtask

  initial begin
    logic [8:0] lit[$];
    int s0, n, w, h, a0, b0;

    // Reset state.
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {19'b0, tft_transmit, done, err, busy, tft_dc, tft_data}, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // 1x1 at origin, orange.
    run_fill(0, 0, 0, 0, 24'hFF8000, 0, 1'b0);
`ifdef TFT_FILL_RGB565_EN
    lit = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h100, 9'h02B, 9'h100, 9'h100,
            9'h100, 9'h100, 9'h02C, 9'h1FC, 9'h100};
    check("1x1_strobes", got_q.size(), 13);
`else
    lit = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h100, 9'h02B, 9'h100, 9'h100,
            9'h100, 9'h100, 9'h02C, 9'h1FF, 9'h180, 9'h100};
    check("1x1_strobes", got_q.size(), 14);
`endif
    cmp_lit("1x1_lit", lit);

    // 3x2 rectangle.
    run_fill(10, 12, 20, 21, 24'h123456, 0, 1'b1);
    lit = '{9'h02A, 9'h100, 9'h10A, 9'h100, 9'h10C, 9'h02B, 9'h100, 9'h114,
            9'h100, 9'h115, 9'h02C};
    cmp_lit("3x2_hdr", lit);
    check("3x2_strobes", got_q.size(), 11 + 6 * BPP);

    // Bottom-right corner pixel: high coordinate bytes are 1.
    run_fill(319, 319, 479, 479, 24'h00FF00, 2, 1'b0);
    lit = '{9'h02A, 9'h101, 9'h13F, 9'h101, 9'h13F, 9'h02B, 9'h101, 9'h1DF,
            9'h101, 9'h1DF, 9'h02C};
    cmp_lit("corner_hdr", lit);

    // Transmitter that never reports busy.
    run_fill(0, 0, 0, 0, 24'hFF8000, 1, 1'b0);
    check("timeout_strobes", got_q.size(), 11 + BPP);

    // Rejected requests.
    bad_start(6, 5, 0, 0);
    bad_start(0, 0, 9, 8);
    bad_start(0, 320, 0, 0);
    bad_start(0, 0, 0, 480);

    // Reset during the pixel phase of a full-screen fill.
    busy_mode = 0;
    build(0, 319, 0, 479, 24'hA5A5A5, 64);
    s0 = strobes;
    @(posedge clk); #1;
    start = 1'b1; x0 = 9'd0; x1 = 9'd319; y0 = 9'd0; y1 = 9'd479; color = 24'hA5A5A5;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (strobes - s0 < 14 && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_pixels", {31'b0, n < BUDGET}, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midfill_reset", {19'b0, tft_transmit, done, err, busy, tft_dc, tft_data}, 0);
    rst = 1'b1;
    exp_q.delete();
    s0 = strobes;
    repeat (20) @(posedge clk);
    #1;
    check("no_strobe_after_reset", strobes - s0, 0);
    check("idle_after_reset", {31'b0, busy}, 0);

    // Randomized rectangles, transmitter timing and mid-fill starts.
    for (int i = 0; i < 10; i++) begin
      w  = $urandom_range(1, 4);
      h  = $urandom_range(1, 3);
      a0 = ($urandom_range(0, 3) == 0) ? 320 - w : $urandom_range(0, 320 - w);
      b0 = ($urandom_range(0, 3) == 0) ? 480 - h : $urandom_range(0, 480 - h);
      run_fill(a0, a0 + w - 1, b0, b0 + h - 1, 24'($urandom),
               $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 3; i++) begin
      a0 = $urandom_range(1, 300);
      b0 = $urandom_range(1, 400);
      case ($urandom_range(0, 3))
        0:       bad_start(a0, a0 - 1, 0, 0);
        1:       bad_start(0, 0, b0, b0 - 1);
        2:       bad_start(a0, $urandom_range(320, 511), 0, 0);
        default: bad_start(0, 0, b0, $urandom_range(480, 511));
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tft_rect_fill.md
TFT_RECT_FILL -- requirements
Module: tft_rect_fill

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-003 SHALL have port: start  input  1  one-cycle request; sampled only in IDLE.
REQ-004 SHALL have ports: x0, x1  input  9 each  inclusive column bounds (0..319).
REQ-005 SHALL have ports: y0, y1  input  9 each  inclusive row bounds (0..479).
REQ-006 SHALL have port: color  input  24  {R,G,B} bytes, captured with start.
REQ-007 SHALL have port: tft_busy  input  1  byte transmitter busy.
REQ-008 SHALL have ports: tft_dc  output  1 (0 = command, 1 = data); tft_data  output  8  byte to send; tft_transmit  output  1  one-cycle send strobe.
REQ-009 SHALL have ports: busy  output  1  fill in progress; done  output  1  one-cycle completion pulse; err  output  1  one-cycle pulse on rejected request.

Function
REQ-010 SHALL capture x0, x1, y0, y1 and color on the cycle start=1 in IDLE; later input changes SHALL NOT affect the running fill.
REQ-011 SHALL reject the request if x1<x0, y1<y0, x1>319 or y1>479: pulse err the next cycle, remain IDLE, emit no bytes.
REQ-012 SHALL emit, in order: CMD 0x2A; DATA x0[8], x0[7:0], x1[8], x1[7:0] (high byte zero-extended); CMD 0x2B; DATA y0 hi/lo, y1 hi/lo; CMD 0x2C; then N = (x1-x0+1)*(y1-y0+1) pixels.
REQ-013 Per pixel, SHALL send R, G, B as DATA bytes, in that order.
REQ-014 SHALL compute N in an 18-bit unsigned counter; the 320x480 maximum of 153600 SHALL NOT overflow it.
REQ-015 Byte handshake: assert tft_transmit for exactly one cycle, with tft_dc/tft_data valid that cycle and held until the next strobe, only when tft_busy=0. Then wait for tft_busy=1, then wait for tft_busy=0 before the next strobe.
REQ-016 If tft_busy is not observed high within 4 cycles of a strobe, SHALL treat the byte as sent and proceed.
REQ-017 States SHALL be IDLE, SEND, WAIT_ACK, WAIT_DONE, FINISH. Transitions: IDLE->SEND on a valid start; SEND->WAIT_ACK after the strobe; WAIT_ACK->WAIT_DONE on busy=1 or timeout; WAIT_DONE->SEND while bytes remain; WAIT_DONE->FINISH after the last byte; FINISH->IDLE after one cycle.
REQ-018 done SHALL pulse in FINISH; busy SHALL be 1 in every state except IDLE.
REQ-019 start while busy=1 SHALL be ignored: no err, no effect on the running fill.
REQ-020 A 1x1 rectangle (x0=x1, y0=y1) SHALL produce exactly 14 strobes: 11 for the window setup and 3 for the pixel.

Reset
REQ-021 While rst=0, at every clock edge: state=IDLE; tft_transmit=0, done=0, err=0, busy=0, tft_dc=0, tft_data=8'h00; counters cleared.
REQ-022 Reset mid-fill SHALL abort immediately; no further strobes after rst returns to 1 until a new start.

Configuration
REQ-023 With macro TFT_FILL_RGB565_EN defined, each pixel SHALL be 2 DATA bytes: {R[7:3],G[7:5]} then {G[4:2],B[7:3]}; a 1x1 fill SHALL produce 13 strobes.
REQ-024 Without TFT_FILL_RGB565_EN, each pixel SHALL be 3 bytes per REQ-013 (RGB666 panel mode).

Structure
REQ-025 Shared package tft_pkg SHALL hold: panel width/height constants (320, 480); command opcodes CASET=8'h2A, RASET=8'h2B, RAMWR=8'h2C; DC encodings; the state enum type.
REQ-026 Handshake (REQ-015/016) SHALL be a sub-module tft_byte_tx: inputs req, dc, data, tft_busy; outputs ack and the tft_* ports.
REQ-027 Byte sequencing and pixel counting SHALL remain in tft_rect_fill.

Verification
REQ-028 Transmitter model with busy rising 1 cycle after a strobe and held 8 cycles; start with (0,0)-(0,0), color 24'hFF8000 -> strobes 2A,00,00,00,00,2B,00,00,00,00,2C,FF,80,00; done pulses once.
REQ-029 start with (10,20)-(12,21) -> 2A,00,0A,00,0C, 2B,00,14,00,15, 2C, then 6 pixels = 18 DATA bytes; busy falls the cycle after done.
REQ-030 start with x1=5, x0=6 -> err pulse; no tft_transmit; busy stays 0.
REQ-031 rst=0 asserted during the pixel phase of (0,0)-(319,479) -> all outputs at reset values next cycle; zero strobes for 20 cycles after release.
REQ-032 Model that never raises busy -> each strobe followed by a 4-cycle timeout; the full 1x1 sequence completes.
REQ-033 TFT_FILL_RGB565_EN defined, 1x1 fill with color 24'hFF8000 -> pixel bytes F C, 00 (i.e. 8'hFC, 8'h00); 13 strobes total.
